// File: rtl/pq_cmd_sched.sv
// rtl/pq_cmd_sched.sv - command FIFO and issue scheduler in front of the register-array priority queue
//
// Purpose: accepts enqueue / dequeue / replace commands from a producer on a
// valid/ready handshake, buffers them in a DEPTH-entry FIFO and issues them to
// the PQ one at a time. Commands that are illegal against the PQ's full/empty
// state are dropped, signalled with a one-cycle pulse and counted.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req_valid/req_ready producer handshake
//   req_enq/req_deq     command type (both set = replace)
//   req_kv              {key,val} carried with an enqueue
//   pq_busy/full/empty  PQ status inputs
//   pq_enq/pq_deq       registered one-cycle strobes to the PQ
//   pq_kvi              {key,val} presented with the strobe, held until next issue
//   ovf_drop/unf_drop   one-cycle drop pulses
//   ovf_cnt/unf_cnt     saturating drop counters
//   fifo_count          number of queued commands
//   idle                FIFO empty and no strobe asserted
module pq_cmd_sched #(
    parameter int KEY_WIDTH = 4,
    parameter int VAL_WIDTH = 4,
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_enq,
    input  logic                           req_deq,
    input  logic [KEY_WIDTH+VAL_WIDTH-1:0] req_kv,
    input  logic                           pq_busy,
    input  logic                           pq_full,
    input  logic                           pq_empty,
    output logic                           pq_enq,
    output logic                           pq_deq,
    output logic [KEY_WIDTH+VAL_WIDTH-1:0] pq_kvi,
    output logic                           ovf_drop,
    output logic                           unf_drop,
    output logic [CNT_W-1:0]               ovf_cnt,
    output logic [CNT_W-1:0]               unf_cnt,
    output logic [$clog2(DEPTH):0]         fifo_count,
    output logic                           idle
);

    localparam int KV_W = KEY_WIDTH + VAL_WIDTH;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;

    // S_IDLE : waiting; the issue decision is taken here and registered.
    // S_ISSUE: the strobe / drop pulse issued on entry is visible this cycle.
    // S_GAP  : one quiet cycle so the PQ can raise pq_busy before the next issue.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t state;

    // FIFO entry layout: {enq, deq, kv}
    logic [KV_W+1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            push;
    logic            pop;
    logic [KV_W+1:0] head;
    logic            h_enq;
    logic            h_deq;
    logic [KV_W-1:0] h_kv;

    assign fifo_count = count;
    assign req_ready  = (count < CW'(DEPTH));
    assign idle       = (count == '0) && !pq_enq && !pq_deq;

    // Requests with neither enq nor deq are consumed by the handshake but never stored.
    assign push  = req_valid && req_ready && (req_enq || req_deq);
    assign pop   = (state == S_IDLE) && (count != '0) && !pq_busy;

    assign head  = mem[rd_ptr];
    assign h_enq = head[KV_W+1];
    assign h_deq = head[KV_W];
    assign h_kv  = head[KV_W-1:0];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {req_enq, req_deq, req_kv};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pq_enq   <= 1'b0;
            pq_deq   <= 1'b0;
            pq_kvi   <= '0;
            ovf_drop <= 1'b0;
            unf_drop <= 1'b0;
            ovf_cnt  <= '0;
            unf_cnt  <= '0;
        end else begin
            pq_enq   <= 1'b0;
            pq_deq   <= 1'b0;
            ovf_drop <= 1'b0;
            unf_drop <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state <= S_ISSUE;
                        if (h_enq && h_deq) begin
                            // Replace is legal when full; on an empty PQ it degrades to a plain enqueue.
                            pq_enq <= 1'b1;
                            pq_deq <= !pq_empty;
                            pq_kvi <= h_kv;
                        end else if (h_enq) begin
                            if (pq_full) begin
                                ovf_drop <= 1'b1;
                                if (ovf_cnt != '1) begin
                                    ovf_cnt <= ovf_cnt + CNT_W'(1);
                                end
                            end else begin
                                pq_enq <= 1'b1;
                                pq_kvi <= h_kv;
                            end
                        end else begin
                            if (pq_empty) begin
                                unf_drop <= 1'b1;
                                if (unf_cnt != '1) begin
                                    unf_cnt <= unf_cnt + CNT_W'(1);
                                end
                            end else begin
                                pq_deq <= 1'b1;
                                pq_kvi <= h_kv;
                            end
                        end
                    end
                end
                S_ISSUE: state <= S_GAP;
                S_GAP:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pq_cmd_sched.sv
// tb/tb_pq_cmd_sched.sv - scoreboard bench for pq_cmd_sched
module tb_pq_cmd_sched;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_enq = 1'b0;
    logic       req_deq = 1'b0;
    logic [7:0] req_kv = 8'h00;
    logic       pq_busy = 1'b0;
    logic       pq_full = 1'b0;
    logic       pq_empty = 1'b1;
    logic       pq_enq;
    logic       pq_deq;
    logic [7:0] pq_kvi;
    logic       ovf_drop;
    logic       unf_drop;
    logic [15:0] ovf_cnt;
    logic [15:0] unf_cnt;
    logic [2:0] fifo_count;
    logic       idle;

    pq_cmd_sched #(.KEY_WIDTH(4), .VAL_WIDTH(4), .DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_enq(req_enq), .req_deq(req_deq), .req_kv(req_kv),
        .pq_busy(pq_busy), .pq_full(pq_full), .pq_empty(pq_empty),
        .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi),
        .ovf_drop(ovf_drop), .unf_drop(unf_drop),
        .ovf_cnt(ovf_cnt), .unf_cnt(unf_cnt),
        .fifo_count(fifo_count), .idle(idle)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event record: {ovf_drop, unf_drop, pq_enq, pq_deq, kv}
    logic [11:0] obs_q[$];
    int          obs_cyc[$];
    logic [11:0] exp_q[$];
    int          rd_i = 0;
    int          checks = 0;
    int          errors = 0;

    always @(negedge clk) begin
        if (!rst && (pq_enq || pq_deq || ovf_drop || unf_drop)) begin
            obs_q.push_back({ovf_drop, unf_drop, pq_enq, pq_deq, pq_kvi});
            obs_cyc.push_back(cyc);
        end
    end

    function automatic logic [3:0] expect_kind(input logic e, input logic d, input logic full, input logic empty);
        if (e && d) return empty ? 4'b0010 : 4'b0011;
        if (e)      return full  ? 4'b1000 : 4'b0010;
        return empty ? 4'b0100 : 4'b0001;
    endfunction

    task automatic push(input logic e, input logic d, input logic [7:0] kv, output int pc);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1; req_enq = e; req_deq = d; req_kv = kv;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        pc = cyc;
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL push_timeout ready=%0b required 1", req_ready);
        end
        if (e || d) exp_q.push_back({expect_kind(e, d, pq_full, pq_empty), kv});
    endtask

    task automatic release_req();
        @(negedge clk);
        req_valid = 1'b0; req_enq = 1'b0; req_deq = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (obs_q.size() < rd_i + exp_q.size() && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", req_ready); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b required 1", idle); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d required 0", fifo_count); end
        checks++; if ({pq_enq, pq_deq, ovf_drop, unf_drop} !== 4'b0) begin errors++; $display("FAIL reset_strobes got %b required 0000", {pq_enq, pq_deq, ovf_drop, unf_drop}); end
        checks++; if (pq_kvi !== 8'h00) begin errors++; $display("FAIL reset_kvi got %h required 00", pq_kvi); end
        checks++; if (ovf_cnt !== 16'd0 || unf_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d required 0/0", ovf_cnt, unf_cnt); end
    endtask

    task automatic test_single();
        int pc, base;
        logic [11:0] want, got;
        pq_full = 1'b0; pq_empty = 1'b1;
        base = rd_i;
        push(1'b1, 1'b0, {4'd8, 4'd14}, pc);
        release_req();
        wait_drain();
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front(); checks++;
            if (rd_i >= obs_q.size()) begin errors++; $display("FAIL single_evt got none required %h", want); end
            else begin
                got = obs_q[rd_i]; rd_i++;
                if (got[11:8] !== want[11:8] || (want[9] && got[7:0] !== want[7:0])) begin
                    errors++; $display("FAIL single_evt got %h required %h", got, want);
                end
            end
        end
        checks++; if (obs_q.size() != rd_i) begin errors++; $display("FAIL single_extra got %0d events required %0d", obs_q.size(), rd_i); end
        checks++;
        if (obs_cyc.size() <= base || obs_cyc[base] != pc + 2) begin
            errors++; $display("FAIL single_latency got cycle %0d required %0d", (obs_cyc.size() > base) ? obs_cyc[base] : -1, pc + 2);
        end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL single_idle got %b required 1", idle); end
    endtask

    task automatic test_back_to_back();
        int pc, pc0, base, peak;
        logic [11:0] want, got;
        pq_full = 1'b0; pq_empty = 1'b0;
        base = rd_i; peak = 0;
        push(1'b1, 1'b0, 8'hBB, pc0);
        push(1'b1, 1'b0, 8'h99, pc); if (int'(fifo_count) > peak) peak = int'(fifo_count);
        push(1'b1, 1'b0, 8'hCC, pc); if (int'(fifo_count) > peak) peak = int'(fifo_count);
        push(1'b0, 1'b1, 8'h00, pc); if (int'(fifo_count) > peak) peak = int'(fifo_count);
        release_req(); if (int'(fifo_count) > peak) peak = int'(fifo_count);
        @(negedge clk); if (int'(fifo_count) > peak) peak = int'(fifo_count);
        checks++; if (peak < 3) begin errors++; $display("FAIL b2b_peak got %0d required >=3", peak); end
        wait_drain();
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front(); checks++;
            if (rd_i >= obs_q.size()) begin errors++; $display("FAIL b2b_evt got none required %h", want); end
            else begin
                got = obs_q[rd_i]; rd_i++;
                if (got[11:8] !== want[11:8] || (want[9] && got[7:0] !== want[7:0])) begin
                    errors++; $display("FAIL b2b_evt got %h required %h", got, want);
                end
            end
        end
        checks++; if (obs_q.size() != rd_i) begin errors++; $display("FAIL b2b_extra got %0d events required %0d", obs_q.size(), rd_i); end
        checks++; if (obs_cyc.size() <= base || obs_cyc[base] != pc0 + 2) begin errors++; $display("FAIL b2b_latency got cycle %0d required %0d", (obs_cyc.size() > base) ? obs_cyc[base] : -1, pc0 + 2); end
        for (int i = base + 1; i < base + 4 && i < obs_cyc.size(); i++) begin
            checks++;
            if (obs_cyc[i] - obs_cyc[i-1] < 2) begin errors++; $display("FAIL b2b_spacing got %0d required >=2", obs_cyc[i] - obs_cyc[i-1]); end
        end
    endtask

    task automatic test_underflow();
        int pc;
        logic [11:0] want, got;
        pq_full = 1'b0; pq_empty = 1'b1;
        push(1'b0, 1'b1, 8'h00, pc);
        push(1'b1, 1'b1, {4'd13, 4'd13}, pc);
        release_req();
        wait_drain();
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front(); checks++;
            if (rd_i >= obs_q.size()) begin errors++; $display("FAIL unf_evt got none required %h", want); end
            else begin
                got = obs_q[rd_i]; rd_i++;
                if (got[11:8] !== want[11:8] || (want[9] && got[7:0] !== want[7:0])) begin
                    errors++; $display("FAIL unf_evt got %h required %h", got, want);
                end
            end
        end
        checks++; if (obs_q.size() != rd_i) begin errors++; $display("FAIL unf_extra got %0d events required %0d", obs_q.size(), rd_i); end
        checks++; if (unf_cnt !== 16'd1) begin errors++; $display("FAIL unf_cnt got %0d required 1", unf_cnt); end
        checks++; if (ovf_cnt !== 16'd0) begin errors++; $display("FAIL unf_ovfcnt got %0d required 0", ovf_cnt); end
    endtask

    task automatic test_overflow();
        int pc;
        logic [11:0] want, got;
        pq_full = 1'b1; pq_empty = 1'b0;
        push(1'b1, 1'b0, 8'h11, pc);
        push(1'b1, 1'b1, 8'h11, pc);
        release_req();
        wait_drain();
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front(); checks++;
            if (rd_i >= obs_q.size()) begin errors++; $display("FAIL ovf_evt got none required %h", want); end
            else begin
                got = obs_q[rd_i]; rd_i++;
                if (got[11:8] !== want[11:8] || (want[9] && got[7:0] !== want[7:0])) begin
                    errors++; $display("FAIL ovf_evt got %h required %h", got, want);
                end
            end
        end
        checks++; if (obs_q.size() != rd_i) begin errors++; $display("FAIL ovf_extra got %0d events required %0d", obs_q.size(), rd_i); end
        checks++; if (ovf_cnt !== 16'd1) begin errors++; $display("FAIL ovf_cnt got %0d required 1", ovf_cnt); end
        checks++; if (unf_cnt !== 16'd1) begin errors++; $display("FAIL ovf_unfcnt got %0d required 1", unf_cnt); end
    endtask

    task automatic test_busy_backpressure();
        int pc;
        logic [11:0] want, got;
        pq_full = 1'b0; pq_empty = 1'b0; pq_busy = 1'b1;
        push(1'b1, 1'b0, 8'h21, pc);
        push(1'b0, 1'b1, 8'h00, pc);
        push(1'b1, 1'b1, 8'h43, pc);
        push(1'b1, 1'b0, 8'h54, pc);
        @(negedge clk);
        req_valid = 1'b1; req_enq = 1'b1; req_deq = 1'b0; req_kv = 8'h65;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_ready got %b required 0", req_ready); end
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL busy_count got %0d required 4", fifo_count); end
        repeat (4) @(negedge clk);
        checks++; if (obs_q.size() != rd_i) begin errors++; $display("FAIL busy_issued got %0d events required %0d", obs_q.size(), rd_i); end
        pq_busy = 1'b0;
        push(1'b1, 1'b0, 8'h65, pc);
        release_req();
        wait_drain();
        while (exp_q.size() > 0) begin
            want = exp_q.pop_front(); checks++;
            if (rd_i >= obs_q.size()) begin errors++; $display("FAIL busy_evt got none required %h", want); end
            else begin
                got = obs_q[rd_i]; rd_i++;
                if (got[11:8] !== want[11:8] || (want[9] && got[7:0] !== want[7:0])) begin
                    errors++; $display("FAIL busy_evt got %h required %h", got, want);
                end
            end
        end
        checks++; if (obs_q.size() != rd_i) begin errors++; $display("FAIL busy_extra got %0d events required %0d", obs_q.size(), rd_i); end
    endtask

    task automatic test_reset_midop();
        int pc;
        pq_full = 1'b0; pq_empty = 1'b0; pq_busy = 1'b1;
        push(1'b1, 1'b0, 8'h31, pc);
        push(1'b1, 1'b0, 8'h32, pc);
        push(1'b0, 1'b1, 8'h00, pc);
        release_req();
        checks++; if (fifo_count !== 3'd3) begin errors++; $display("FAIL midrst_pre got %0d required 3", fifo_count); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; pq_busy = 1'b0;
        exp_q.delete();
        repeat (10) @(negedge clk);
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d required 0", fifo_count); end
        checks++; if (obs_q.size() != rd_i) begin errors++; $display("FAIL midrst_strobe got %0d events required %0d", obs_q.size(), rd_i); end
        checks++; if (ovf_cnt !== 16'd0 || unf_cnt !== 16'd0) begin errors++; $display("FAIL midrst_cnt got %0d/%0d required 0/0", ovf_cnt, unf_cnt); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL midrst_idle got %b required 1", idle); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_underflow();
        test_overflow();
        test_busy_backpressure();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
